ipm2t_hssthp_tx_comma_insert_40b: RTL
=====================================

IPM2T_HSSTHP_TX_COMMA_INSERT_40B -- requirements
Module: ipm2t_hssthp_tx_comma_insert_40b

Interface
REQ-001 The block SHALL use clock clk; reset rst_n is asynchronous, active-low.
REQ-002 clk  input  1  TX user-side PCS clock; all logic in this single domain.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 enable  input  1  block enable; low forces the IDLE state.
REQ-005 cfg_comma_reg0  input  8  K-code comma byte value (default 8'hBC).
REQ-006 cfg_data_width  input  2  2'b00 = 32-bit lane, 2'b10 = 64-bit; other values SHALL be treated as 32-bit.
REQ-007 cfg_train_len  input  8  number of training comma words after enable; 0 SHALL be treated as 1.
REQ-008 cfg_idle_period  input  16  data words between forced comma insertions; 0 disables periodic insertion.
REQ-009 i_txd  input  64  user data, byte n at [8n+7:8n].
REQ-010 i_txk  input  8  per-byte K flag for i_txd.
REQ-011 i_txvalid  input  1  user word valid.
REQ-012 o_txready  output  1  registered; word accepted when i_txvalid and o_txready are both high.
REQ-013 o_txd  output  80  to HSST PCS TX; [79:64] always 0.
REQ-014 o_txk  output  8  per-byte K flag to PCS.
REQ-015 o_train_done  output  1  high from the first DATA-state cycle until enable falls.

Function
REQ-016 Comma word SHALL be, per active 32-bit lane: byte0 = cfg_comma_reg0 with K=1, bytes1..3 = 8'h50 (D16.2) with K=0; in 32-bit mode lane 1 bytes and K bits SHALL be 0.
REQ-017 States SHALL be IDLE, TRAIN, DATA; enable low in any state SHALL move to IDLE next clock.
REQ-018 IDLE: o_txd = 0, o_txk = 0, o_txready = 0, o_train_done = 0; enable high SHALL move to TRAIN and load the train counter.
REQ-019 TRAIN: one comma word per cycle for exactly max(cfg_train_len,1) cycles, o_txready = 0, then DATA.
REQ-020 DATA: o_txready SHALL be high except in the cycle a forced insertion is due.
REQ-021 Accepted word SHALL appear on o_txd[63:0]/o_txk with exactly 1 clock latency; in 32-bit mode bits [63:32] and o_txk[7:4] SHALL be forced 0.
REQ-022 Cycle in DATA with no transfer SHALL emit a comma word (idle fill) and clear the period counter.
REQ-023 Period counter SHALL increment per accepted word; after cfg_idle_period consecutive accepted words o_txready SHALL go low for exactly one cycle, during which a comma word is emitted and the counter clears.
REQ-024 cfg_idle_period = 0: o_txready SHALL stay high in DATA; counter held at 0.
REQ-025 Counter SHALL saturate, never wrap, if cfg_idle_period changes below current count; insertion then occurs on the next accepted word.
REQ-026 enable falling with i_txvalid high SHALL not accept the word (o_txready low next cycle); output zero from the following cycle.
REQ-027 Configuration inputs SHALL be treated quasi-static; changes outside IDLE need not be glitch-free.

Reset
REQ-028 During rst_n low: state IDLE, all counters 0, o_txd = 0, o_txk = 0, o_txready = 0, o_train_done = 0.
REQ-029 Reset deassertion with enable high SHALL enter TRAIN on the first clock edge after release.
REQ-030 Reset mid-TRAIN or mid-DATA SHALL discard in-flight words; no partial word output.

Verification
REQ-031 32-bit, train_len=4, comma=8'hBC: enable high -> 4 cycles o_txd[31:0]=32'h505050BC, o_txk=8'h01, then o_txready=1, o_train_done=1.
REQ-032 64-bit, train_len=0: one comma word o_txd[63:0]=64'h505050BC_505050BC, o_txk=8'h11, then DATA.
REQ-033 64-bit, idle_period=3, continuous valid words 1..6 -> o_txd sequence 1,2,3,comma,4,5,6,comma; o_txready low one cycle after each 3rd accept.
REQ-034 32-bit, i_txd=64'hFFFF_FFFF_1234_5678, i_txk=8'hF0 -> o_txd=80'h0000_0000_0000_1234_5678, o_txk=8'h00 one cycle after accept.
REQ-035 i_txvalid gap of 2 cycles in DATA -> 2 comma words out, period counter cleared (next insertion after 3 further accepts).
REQ-036 enable dropped mid-DATA and rst_n pulsed mid-TRAIN -> all outputs 0 next cycle/immediately; re-enable restarts full training.

Source files
------------

// File: rtl/ipm2t_hssthp_tx_comma_insert_40b.sv
// TX comma inserter for the HSST PCS user side: runs comma training after enable,
// then forwards user words and keeps the link aligned with idle-fill and periodic commas.
module ipm2t_hssthp_tx_comma_insert_40b (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  cfg_comma_reg0,
  input  logic [1:0]  cfg_data_width,
  input  logic [7:0]  cfg_train_len,
  input  logic [15:0] cfg_idle_period,
  input  logic [63:0] i_txd,
  input  logic [7:0]  i_txk,
  input  logic        i_txvalid,
  output logic        o_txready,
  output logic [79:0] o_txd,
  output logic [7:0]  o_txk,
  output logic        o_train_done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRAIN,
    ST_DATA
  } state_e;

  state_e      state_q;
  logic [7:0]  train_cnt_q;
  logic [15:0] period_cnt_q;
  logic [15:0] period_cnt_d;
  logic [63:0] txd_q;
  logic [7:0]  txk_q;
  logic        txready_q;
  logic        train_done_q;

  logic        wide;
  logic [31:0] comma_lane;
  logic [63:0] comma_txd;
  logic [7:0]  comma_txk;
  logic [63:0] data_txd;
  logic [7:0]  data_txk;
  logic [7:0]  train_load;
  logic        transfer;
  logic        insert_due;

  // Only 2'b10 selects the 64-bit lane pair; every other code behaves as 32-bit.
  assign wide       = (cfg_data_width == 2'b10);
  assign comma_lane = {8'h50, 8'h50, 8'h50, cfg_comma_reg0};
  assign comma_txd  = wide ? {comma_lane, comma_lane} : {32'h0, comma_lane};
  assign comma_txk  = wide ? 8'h11 : 8'h01;
  assign data_txd   = wide ? i_txd : {32'h0, i_txd[31:0]};
  assign data_txk   = wide ? i_txk : {4'h0, i_txk[3:0]};
  assign train_load = (cfg_train_len == 8'd0) ? 8'd1 : cfg_train_len;

  // A falling enable overrides a pending handshake so no word is taken on the way out.
  assign transfer   = enable && (state_q == ST_DATA) && txready_q && i_txvalid;

  // NOTE: default assignment first so the combinational block never infers a latch.
  always_comb begin
    period_cnt_d = '0;
    if (transfer && (cfg_idle_period != 16'd0)) begin
      period_cnt_d = (&period_cnt_q) ? period_cnt_q : period_cnt_q + 16'd1;
    end
  end

  // Compare with >= so a period lowered below the running count still forces an insertion.
  assign insert_due = (cfg_idle_period != 16'd0) && (period_cnt_d >= cfg_idle_period);

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      train_cnt_q  <= '0;
      period_cnt_q <= '0;
      txd_q        <= '0;
      txk_q        <= '0;
      txready_q    <= 1'b0;
      train_done_q <= 1'b0;
    end else if (!enable) begin
      state_q      <= ST_IDLE;
      train_cnt_q  <= '0;
      period_cnt_q <= '0;
      txd_q        <= '0;
      txk_q        <= '0;
      txready_q    <= 1'b0;
      train_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q      <= ST_TRAIN;
          train_cnt_q  <= train_load;
          period_cnt_q <= '0;
          txd_q        <= comma_txd;
          txk_q        <= comma_txk;
          txready_q    <= 1'b0;
          train_done_q <= 1'b0;
        end
        ST_TRAIN: begin
          txd_q        <= comma_txd;
          txk_q        <= comma_txk;
          period_cnt_q <= '0;
          if (train_cnt_q <= 8'd1) begin
            state_q      <= ST_DATA;
            train_cnt_q  <= '0;
            txready_q    <= 1'b1;
            train_done_q <= 1'b1;
          end else begin
            train_cnt_q  <= train_cnt_q - 8'd1;
            txready_q    <= 1'b0;
            train_done_q <= 1'b0;
          end
        end
        ST_DATA: begin
          txd_q        <= transfer ? data_txd : comma_txd;
          txk_q        <= transfer ? data_txk : comma_txk;
          period_cnt_q <= period_cnt_d;
          txready_q    <= !insert_due;
          train_done_q <= 1'b1;
        end
        default: begin
          state_q      <= ST_IDLE;
          train_cnt_q  <= '0;
          period_cnt_q <= '0;
          txd_q        <= '0;
          txk_q        <= '0;
          txready_q    <= 1'b0;
          train_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_txd        = {16'h0, txd_q};
  assign o_txk        = txk_q;
  assign o_txready    = txready_q;
  assign o_train_done = train_done_q;

endmodule
